// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game-wide object identifiers shared across the frame pipeline
package game_pkg;

  typedef enum logic [1:0] {
    OBJECT_NONE  = 2'd0,
    OBJECT_CAR1  = 2'd1,
    OBJECT_CAR2  = 2'd2,
    OBJECT_TRACK = 2'd3
  } ObjectID;

endpackage

// File: rtl/sprite_row_fetcher_pkg.sv
// rtl/sprite_row_fetcher_pkg.sv - fetcher FSM states and sprite base selection
package sprite_row_fetcher_pkg;
  import game_pkg::*;
  import sram_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  function automatic logic is_car(input ObjectID id);
    return (id == OBJECT_CAR1) || (id == OBJECT_CAR2);
  endfunction

  function automatic logic [SRAM_ADDR_COUNT-1:0] sprite_base(input ObjectID id);
    return (id == OBJECT_CAR2) ? CAR2_SPRITE_BASE : CAR1_SPRITE_BASE;
  endfunction

endpackage

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - external SRAM geometry and sprite region bases shared by encoder and fetcher
package sram_pkg;

  localparam int SRAM_ADDR_COUNT = 20;
  localparam int SRAM_DATA_WIDTH = 16;

  localparam logic [SRAM_ADDR_COUNT-1:0] CAR1_SPRITE_BASE = 20'h0_8000;
  localparam logic [SRAM_ADDR_COUNT-1:0] CAR2_SPRITE_BASE = 20'h0_9000;

endpackage

// File: rtl/sprite_row_fetcher_buffer.sv
// rtl/sprite_row_fetcher_buffer.sv - ping-pong row storage, one write port and one registered read port
module sprite_row_buffer #(
  parameter int IMAGE_SIZE = 64,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = $clog2(IMAGE_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_bank,
  input  logic [IDX_WIDTH-1:0]  i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_we,
  input  logic                  i_rd_bank,
  input  logic [IDX_WIDTH-1:0]  i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  // Bank select is the MSB of the flat storage index.
  logic [DATA_WIDTH-1:0] mem_q [2*IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[{i_wr_bank, i_wr_idx}] <= i_wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem_q[{i_rd_bank, i_rd_idx}];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/sprite_row_fetcher.sv
// rtl/sprite_row_fetcher.sv - fetches one car sprite row from SRAM into a ping-pong row buffer
module sprite_row_fetcher
  import game_pkg::*;
  import sram_pkg::*;
  import sprite_row_fetcher_pkg::*;
#(
  parameter int IMAGE_SIZE = 64,
  parameter int ADDR_WIDTH = SRAM_ADDR_COUNT,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(IMAGE_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  ObjectID               i_object_id,
  input  logic [IDX_WIDTH:0]    i_row,
  input  logic                  i_bus_busy,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic                  i_swap,
  output logic                  o_bank_full,
  input  logic [IDX_WIDTH-1:0]  i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  fetch_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_WIDTH-1:0]  row_q, row_d;
  logic [IDX_WIDTH-1:0]  col_q, col_d;
  logic                  display_q, display_d;
  logic                  bank_full_q, bank_full_d;
  logic                  err_q, err_d;

  logic start_ok;
  logic issue;
  logic last_col;
  logic swap_ok;

  assign start_ok = i_start && (i_row < (IDX_WIDTH+1)'(IMAGE_SIZE)) && is_car(i_object_id);
  assign issue    = (state_q == ST_FETCH) && !i_bus_busy;
  assign last_col = (col_q == IDX_WIDTH'(IMAGE_SIZE - 1));
  assign swap_ok  = i_swap && (state_q != ST_FETCH);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      display_q   <= 1'b0;
      bank_full_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      row_q       <= row_d;
      col_q       <= col_d;
      display_q   <= display_d;
      bank_full_q <= bank_full_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_FETCH;
      ST_FETCH: if (issue && last_col) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    row_d       = row_q;
    col_d       = col_q;
    display_d   = display_q;
    bank_full_d = bank_full_q;
    err_d       = 1'b0;
    if ((state_q == ST_IDLE) && i_start) begin
      if (start_ok) begin
        base_d      = ADDR_WIDTH'(sprite_base(i_object_id));
        row_d       = i_row[IDX_WIDTH-1:0];
        col_d       = '0;
        bank_full_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (issue) begin
      col_d = col_q + 1'b1;
      if (last_col) bank_full_d = 1'b1;
    end
    // A swap in the DONE cycle overrides the row-complete flag set on entry.
    if (swap_ok) begin
      display_d   = ~display_q;
      bank_full_d = 1'b0;
    end
  end

  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_done      = (state_q == ST_DONE);
    o_err       = err_q;
    o_bank_full = bank_full_q;
    o_sram_addr = base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(IMAGE_SIZE) + ADDR_WIDTH'(col_q);
  end

  sprite_row_buffer #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_row_buffer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_bank (~display_q),
    .i_wr_idx  (col_q),
    .i_wr_data (i_sram_data),
    .i_we      (issue),
    .i_rd_bank (display_q),
    .i_rd_idx  (i_rd_idx),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// tb/tb_sprite_row_fetcher.sv - directed self-checking bench for sprite_row_fetcher
module tb_sprite_row_fetcher;
  import game_pkg::*;
  import sram_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  ObjectID     i_object_id;
  logic [6:0]  i_row;
  logic        i_bus_busy;
  logic [15:0] i_sram_data;
  logic [19:0] o_sram_addr;
  logic        o_busy, o_done, o_err;
  logic        i_swap;
  logic        o_bank_full;
  logic [5:0]  i_rd_idx;
  logic [15:0] o_rd_data;

  int checks   = 0;
  int failures = 0;
  bit sram_const = 1'b0;

  sprite_row_fetcher dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_object_id (i_object_id),
    .i_row       (i_row),
    .i_bus_busy  (i_bus_busy),
    .i_sram_data (i_sram_data),
    .o_sram_addr (o_sram_addr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .i_swap      (i_swap),
    .o_bank_full (o_bank_full),
    .i_rd_idx    (i_rd_idx),
    .o_rd_data   (o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] sram_word(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A ^ {12'h000, a[19:16]};
  endfunction

  assign i_sram_data = sram_const ? 16'hAAAA : sram_word(o_sram_addr);

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL %s o_busy got %0b want 0", name, o_busy); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL %s o_done got %0b want 0", name, o_done); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL %s o_err got %0b want 0", name, o_err); end
    checks++; if (o_bank_full !== 1'b0) begin failures++; $display("FAIL %s o_bank_full got %0b want 0", name, o_bank_full); end
    checks++; if (o_sram_addr !== 20'h0) begin failures++; $display("FAIL %s o_sram_addr got %h want 0", name, o_sram_addr); end
    checks++; if (o_rd_data !== 16'h0) begin failures++; $display("FAIL %s o_rd_data got %h want 0", name, o_rd_data); end
  endtask

  task automatic do_fetch(input string name, input ObjectID obj, input int row,
                          input int stall_col, input int stall_len,
                          input bit swap_mid, input bit swap_done, input bit rd_const);
    logic [19:0] base;
    logic [19:0] exp_addr;
    int cyc, col, stalled;
    base = (obj == OBJECT_CAR2) ? CAR2_SPRITE_BASE : CAR1_SPRITE_BASE;
    i_object_id = obj;
    i_row = 7'(row);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 1; col = 0; stalled = 0;
    while (o_done !== 1'b1 && cyc < 200) begin
      exp_addr = base + 20'(row * 64 + col);
      checks++;
      if (o_sram_addr !== exp_addr) begin
        failures++; $display("FAIL %s addr cyc%0d got %h want %h", name, cyc, o_sram_addr, exp_addr);
      end
      if (rd_const) begin
        checks++;
        if (o_rd_data !== 16'hAAAA) begin
          failures++; $display("FAIL %s display_read cyc%0d got %h want aaaa", name, cyc, o_rd_data);
        end
        i_rd_idx = 6'(cyc);
      end
      i_bus_busy = (col == stall_col) && (stalled < stall_len);
      if (i_bus_busy) stalled++;
      else col++;
      i_swap = swap_mid && (cyc == 5);
      tick();
      cyc++;
    end
    i_bus_busy = 1'b0;
    i_swap = 1'b0;
    checks++;
    if (cyc !== 65 + stall_len) begin
      failures++; $display("FAIL %s done_latency got %0d want %0d", name, cyc, 65 + stall_len);
    end
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL %s busy_in_done got %0b want 1", name, o_busy); end
    i_swap = swap_done;
    tick();
    i_swap = 1'b0;
    checks++;
    if (o_bank_full !== !swap_done) begin
      failures++; $display("FAIL %s bank_full got %0b want %0b", name, o_bank_full, !swap_done);
    end
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++; $display("FAIL %s idle_after_done busy=%0b done=%0b want 0 0", name, o_busy, o_done);
    end
  endtask

  task automatic do_swap(input string name);
    i_swap = 1'b1;
    tick();
    i_swap = 1'b0;
    checks++;
    if (o_bank_full !== 1'b0) begin failures++; $display("FAIL %s swap_clears_full got %0b want 0", name, o_bank_full); end
  endtask

  task automatic read_row(input string name, input ObjectID obj, input int row);
    logic [19:0] base;
    logic [15:0] exp;
    base = (obj == OBJECT_CAR2) ? CAR2_SPRITE_BASE : CAR1_SPRITE_BASE;
    for (int i = 0; i < 64; i++) begin
      i_rd_idx = 6'(i);
      tick();
      exp = sram_word(base + 20'(row * 64 + i));
      checks++;
      if (o_rd_data !== exp) begin
        failures++; $display("FAIL %s read idx%0d got %h want %h", name, i, o_rd_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    tick();
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_basic_fetch();
    do_fetch("basic", OBJECT_CAR1, 3, -1, 0, 1'b0, 1'b0, 1'b0);
    do_swap("basic");
    read_row("basic", OBJECT_CAR1, 3);
  endtask

  task automatic test_stall();
    do_fetch("stall", OBJECT_CAR1, 3, 10, 5, 1'b0, 1'b0, 1'b0);
    do_swap("stall");
    read_row("stall", OBJECT_CAR1, 3);
  endtask

  task automatic test_err();
    i_object_id = OBJECT_CAR1; i_row = 7'd64; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_row o_err got %0b want 1", o_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL err_row o_busy got %0b want 0", o_busy); end
    tick();
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_row pulse_width o_err got %0b want 0", o_err); end
    i_object_id = OBJECT_TRACK; i_row = 7'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_id o_err got %0b want 1", o_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL err_id o_busy got %0b want 0", o_busy); end
    tick();
    checks++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin failures++; $display("FAIL err_id settle busy=%0b err=%0b want 0 0", o_busy, o_err); end
  endtask

  task automatic test_read_during_fetch();
    sram_const = 1'b1;
    do_fetch("fill_aaaa", OBJECT_CAR1, 5, -1, 0, 1'b0, 1'b0, 1'b0);
    sram_const = 1'b0;
    do_swap("fill_aaaa");
    i_rd_idx = 6'd0;
    tick();
    do_fetch("rd_during", OBJECT_CAR2, 0, -1, 0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o_rd_data !== 16'hAAAA) begin failures++; $display("FAIL rd_during still_old got %h want aaaa", o_rd_data); end
    do_swap("rd_during");
    read_row("rd_during", OBJECT_CAR2, 0);
  endtask

  task automatic test_swap_in_done();
    do_fetch("swap_done", OBJECT_CAR1, 1, -1, 0, 1'b0, 1'b1, 1'b0);
    read_row("swap_done", OBJECT_CAR1, 1);
  endtask

  task automatic test_reset_mid_fetch();
    i_object_id = OBJECT_CAR2; i_row = 7'd9; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (30) tick();
    checks++;
    if (o_sram_addr !== CAR2_SPRITE_BASE + 20'(9 * 64 + 30)) begin
      failures++; $display("FAIL rst_mid pre_addr got %h want %h", o_sram_addr, CAR2_SPRITE_BASE + 20'(9 * 64 + 30));
    end
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_async");
    tick();
    check_reset_outputs("rst_mid_edge");
    i_rst_n = 1'b1;
    tick();
    do_fetch("after_rst", OBJECT_CAR2, 9, -1, 0, 1'b0, 1'b0, 1'b0);
    do_swap("after_rst");
    read_row("after_rst", OBJECT_CAR2, 9);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_object_id = OBJECT_NONE;
    i_row = '0;
    i_bus_busy = 1'b0;
    i_swap = 1'b0;
    i_rd_idx = '0;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_err();
    test_read_during_fetch();
    test_swap_in_done();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
